ring_switch_arbiter: RTL and testbench
======================================

Name: ring_switch_arbiter

Overview:
- Parametrised, registered successor to the ring router's switch control.
- Routes flits arriving from the upstream ring VC either to local ejection (when the head destination equals this node) or to the downstream ring output.
- Arbitrates the ring output between through-traffic and local NI injection, locking the output for whole packets (head to trailer) and granting round-robin.
- Both outputs are one-entry registered buffers with valid/ready handshakes. Ejection and injection may proceed concurrently.

Parameters:
- FLIT_W, 8, flit width in bits.
- NODE_W, 2, destination/node-ID field width; occupies flit[NODE_W-1:0] of a head flit.
- HEAD_TAG, 6'b101111, width FLIT_W-NODE_W; a head flit has flit[FLIT_W-1:NODE_W]==HEAD_TAG.
- TRAILER, all-ones of FLIT_W, the trailer flit value; it closes the packet.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- current_node  in  NODE_W  this router's node ID; static during operation
- ring_in_flit  in  FLIT_W  flit from upstream ring VC
- ring_in_valid  in  1  ring_in_flit valid
- ring_in_ready  out  1  ring input accepted this cycle when valid&ready
- ni_in_flit  in  FLIT_W  flit from local NI
- ni_in_valid  in  1  ni_in_flit valid
- ni_in_ready  out  1  NI flit accepted when valid&ready (replaces noc_ready)
- ring_out_flit  out  FLIT_W  flit to downstream ring
- ring_out_valid  out  1  ring_out_flit valid
- ring_out_ready  in  1  downstream accepts
- ej_flit  out  FLIT_W  flit ejected to local NI
- ej_valid  out  1  ej_flit valid
- ej_ready  in  1  local NI accepts
- ring_out_src  out  1  source of the ring_out buffer: 0=ring, 1=NI
- err_drop  out  1  one-cycle pulse when a non-head flit arrives outside a packet and is dropped

Behaviour:
- Reset (rst high at posedge):
  - All state machines go to idle; rr pointer = 0.
  - Both output buffers are emptied.
  - ring_out_valid=0, ej_valid=0, ring_out_flit=0, ej_flit=0, ring_out_src=0, err_drop=0.
  - This applies mid-packet too: partial packets are abandoned and no flit is emitted afterward.
- Buffer rule: an output buffer "can load" when it is empty or being drained this cycle (valid&ready). Loading sets valid on the next edge. Latency is exactly 1 cycle from input handshake to output valid, and there is no bubble under continuous ready.
- Ring-input router FSM, states R_IDLE, R_EJECT, R_FWD:
  - R_IDLE, ring head with dest==current_node: ready = ej can-load; on accept, load ej and go to R_EJECT.
  - R_IDLE, ring head with dest!=current_node: ready = ring_out can-load AND ring is granted the output (see arbiter); on accept, load ring_out and go to R_FWD.
  - R_IDLE, ring non-head flit: ready=1; the flit is dropped and err_drop pulses.
  - R_EJECT / R_FWD: body flits go to the same target, ready = target can-load. Accepting TRAILER returns the FSM to R_IDLE.
- Output owner FSM, states O_FREE, O_RING, O_NI:
  - O_FREE, contenders: a ring head (non-local) in R_IDLE, and an NI head (flit[FLIT_W-1:NODE_W]==HEAD_TAG) with ni_in_valid.
  - Single contender: that contender wins.
  - Both: rr=0 grants ring, rr=1 grants NI. After the grant, rr points to the loser.
  - The grant takes effect in the same cycle as the head handshake. Owner becomes O_RING/O_NI only when the head is accepted.
  - The owner holds until its TRAILER is accepted, then returns to O_FREE. The next packet may be granted in the following cycle.
  - While O_RING, ni_in_ready=0. While O_NI, ring forwarding is stalled, but ring ejection is not.
- NI path:
  - NI packets always go to ring_out regardless of dest; there is no local loopback.
  - An NI non-head flit in O_FREE with no NI packet open is accepted, dropped, and pulses err_drop.
  - ring_out_src is registered alongside the flit.
- Simultaneous drops on both inputs produce a single err_drop pulse.
- A stalled downstream (ready=0) holds the buffer contents and valid stable. Inputs then back-pressure via ready=0 with no loss.
- Packets never interleave on ring_out.

Test Plan:
- current_node=2. Ring sends 0xBE, 0x55, 0xFF with ej_ready=1 -> ej_valid appears 1 cycle after each accept with values 0xBE, 0x55, 0xFF; ring_out_valid stays 0.
- Ring sends 0xBD, 0x11, 0xFF -> ring_out carries 0xBD, 0x11, 0xFF with ring_out_src=0; ej_valid stays 0.
- Ring head 0xBD and NI head 0xBC arrive in the same cycle after reset (rr=0):
  - Ring packet completes first; ni_in_ready=0 until the ring trailer is accepted.
  - NI packet follows with src=1.
  - Repeating the tie grants NI first.
- ring_out_ready=0 for 5 cycles mid-packet -> ring_out_flit holds and ring_in_ready=0; after release the flits arrive in order with none lost or duplicated.
- Ring non-head 0x42 while idle -> accepted, err_drop=1 for one cycle, and no output valid.
- Local eject packet 0xBE... concurrent with NI inject 0xBD...:
  - Both progress every cycle.
  - Asserting rst mid-packet clears all valids next cycle.
  - A fresh head is routed normally afterward.

Source files
------------

// File: rtl/ring_switch_arbiter.sv
// Ring router switch control with registered outputs.
// Routes upstream ring flits to local ejection or the downstream ring, and
// arbitrates the downstream ring between through-traffic and NI injection,
// holding the output for whole packets and granting ties round-robin.
module ring_switch_arbiter #(
  parameter int unsigned                FLIT_W   = 8,
  parameter int unsigned                NODE_W   = 2,
  parameter logic [FLIT_W-NODE_W-1:0]   HEAD_TAG = 6'b101111,
  parameter logic [FLIT_W-1:0]          TRAILER  = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NODE_W-1:0] current_node,
  input  logic [FLIT_W-1:0] ring_in_flit,
  input  logic              ring_in_valid,
  output logic              ring_in_ready,
  input  logic [FLIT_W-1:0] ni_in_flit,
  input  logic              ni_in_valid,
  output logic              ni_in_ready,
  output logic [FLIT_W-1:0] ring_out_flit,
  output logic              ring_out_valid,
  input  logic              ring_out_ready,
  output logic [FLIT_W-1:0] ej_flit,
  output logic              ej_valid,
  input  logic              ej_ready,
  output logic              ring_out_src,
  output logic              err_drop
);

  typedef enum logic [1:0] {R_IDLE, R_EJECT, R_FWD} r_state_t;
  typedef enum logic [1:0] {O_FREE, O_RING, O_NI}   o_state_t;

  r_state_t r_state, r_next;
  o_state_t o_state, o_next;
  logic     rr, rr_next;

  logic ring_head, ring_local, ring_trailer;
  logic ni_head, ni_trailer;
  logic ro_can_load, ej_can_load;
  logic ring_req, ni_req, gnt_ring, gnt_ni;
  logic ro_load_ring, ro_load_ni, ej_load;
  logic ring_drop, ni_drop;

  assign ring_head    = (ring_in_flit[FLIT_W-1:NODE_W] == HEAD_TAG);
  assign ring_local   = (ring_in_flit[NODE_W-1:0] == current_node);
  assign ring_trailer = (ring_in_flit == TRAILER);
  assign ni_head      = (ni_in_flit[FLIT_W-1:NODE_W] == HEAD_TAG);
  assign ni_trailer   = (ni_in_flit == TRAILER);

  // A buffer may take a new flit when empty or when it is being drained now.
  assign ro_can_load = !ring_out_valid || ring_out_ready;
  assign ej_can_load = !ej_valid || ej_ready;

  // Contenders for a free output; grant resolves same-cycle ties by rr.
  assign ring_req = ring_in_valid && (r_state == R_IDLE) && ring_head && !ring_local;
  assign ni_req   = ni_in_valid && ni_head;
  assign gnt_ring = (o_state == O_FREE) && ring_req && (!ni_req || !rr);
  assign gnt_ni   = (o_state == O_FREE) && ni_req && (!ring_req || rr);

  // State registers for the ring router, output owner and rr pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      o_state <= O_FREE;
      rr      <= 1'b0;
    end else begin
      r_state <= r_next;
      o_state <= o_next;
      rr      <= rr_next;
    end
  end

  // Ring-input router: picks a target per packet and back-pressures on it.
  always_comb begin
    r_next        = r_state;
    ring_in_ready = 1'b0;
    ro_load_ring  = 1'b0;
    ej_load       = 1'b0;
    ring_drop     = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (ring_head) begin
          if (ring_local) begin
            ring_in_ready = ej_can_load;
            if (ring_in_valid && ring_in_ready) begin
              ej_load = 1'b1;
              r_next  = R_EJECT;
            end
          end else begin
            ring_in_ready = ro_can_load && gnt_ring;
            if (ring_in_valid && ring_in_ready) begin
              ro_load_ring = 1'b1;
              r_next       = R_FWD;
            end
          end
        end else begin
          ring_in_ready = 1'b1;
          ring_drop     = ring_in_valid;
        end
      end
      R_EJECT: begin
        ring_in_ready = ej_can_load;
        if (ring_in_valid && ring_in_ready) begin
          ej_load = 1'b1;
          if (ring_trailer) r_next = R_IDLE;
        end
      end
      R_FWD: begin
        ring_in_ready = ro_can_load;
        if (ring_in_valid && ring_in_ready) begin
          ro_load_ring = 1'b1;
          if (ring_trailer) r_next = R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Output owner: locks ring_out to one source from head to trailer.
  // The ring side's ownership is inferred from its forwarding loads so the
  // two combinational blocks stay acyclic.
  always_comb begin
    o_next      = o_state;
    rr_next     = rr;
    ni_in_ready = 1'b0;
    ro_load_ni  = 1'b0;
    ni_drop     = 1'b0;
    unique case (o_state)
      O_FREE: begin
        if (ro_load_ring) begin
          o_next = O_RING;
          if (ni_req) rr_next = 1'b1;
        end
        if (ni_head) begin
          ni_in_ready = ro_can_load && gnt_ni;
          if (ni_in_valid && ni_in_ready) begin
            ro_load_ni = 1'b1;
            o_next     = O_NI;
            if (ring_req) rr_next = 1'b0;
          end
        end else begin
          ni_in_ready = 1'b1;
          ni_drop     = ni_in_valid;
        end
      end
      O_RING: begin
        if (ro_load_ring && ring_trailer) o_next = O_FREE;
      end
      O_NI: begin
        ni_in_ready = ro_can_load;
        if (ni_in_valid && ni_in_ready) begin
          ro_load_ni = 1'b1;
          if (ni_trailer) o_next = O_FREE;
        end
      end
      default: o_next = O_FREE;
    endcase
  end

  // Downstream ring buffer: one entry, source tag travels with the flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ring_out_valid <= 1'b0;
      ring_out_flit  <= '0;
      ring_out_src   <= 1'b0;
    end else if (ro_load_ring) begin
      ring_out_valid <= 1'b1;
      ring_out_flit  <= ring_in_flit;
      ring_out_src   <= 1'b0;
    end else if (ro_load_ni) begin
      ring_out_valid <= 1'b1;
      ring_out_flit  <= ni_in_flit;
      ring_out_src   <= 1'b1;
    end else if (ring_out_ready) begin
      ring_out_valid <= 1'b0;
    end
  end

  // Local ejection buffer: one entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      ej_valid <= 1'b0;
      ej_flit  <= '0;
    end else if (ej_load) begin
      ej_valid <= 1'b1;
      ej_flit  <= ring_in_flit;
    end else if (ej_ready) begin
      ej_valid <= 1'b0;
    end
  end

  // Drop indication: one pulse covers drops on either or both inputs.
  always_ff @(posedge clk) begin
    if (rst) err_drop <= 1'b0;
    else     err_drop <= ring_drop || ni_drop;
  end

endmodule

// File: tb/tb_ring_switch_arbiter.sv
// Bench for ring_switch_arbiter: directed cycle vectors followed by random
// packet traffic checked against a handshake-level reference model.
module tb_ring_switch_arbiter;

  localparam logic [5:0] HT   = 6'b101111;
  localparam logic [1:0] NODE = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] current_node;
  logic [7:0] ring_in_flit, ni_in_flit, ring_out_flit, ej_flit;
  logic       ring_in_valid, ring_in_ready, ni_in_valid, ni_in_ready;
  logic       ring_out_valid, ring_out_ready, ej_valid, ej_ready;
  logic       ring_out_src, err_drop;

  always #5 clk = ~clk;

  ring_switch_arbiter #(
    .FLIT_W(8), .NODE_W(2), .HEAD_TAG(6'b101111), .TRAILER(8'hFF)
  ) dut (
    .clk(clk), .rst(rst), .current_node(current_node),
    .ring_in_flit(ring_in_flit), .ring_in_valid(ring_in_valid), .ring_in_ready(ring_in_ready),
    .ni_in_flit(ni_in_flit), .ni_in_valid(ni_in_valid), .ni_in_ready(ni_in_ready),
    .ring_out_flit(ring_out_flit), .ring_out_valid(ring_out_valid), .ring_out_ready(ring_out_ready),
    .ej_flit(ej_flit), .ej_valid(ej_valid), .ej_ready(ej_ready),
    .ring_out_src(ring_out_src), .err_drop(err_drop)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst; logic [7:0] rf; logic rv; logic [7:0] nf; logic nv; logic ror; logic ejr;
    logic rir; logic nir; logic rov; logic [7:0] rof; logic ros; logic ejv; logic [7:0] ejf; logic err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [7:0] rf, input logic rv, input logic [7:0] nf,
                     input logic nv, input logic ror, input logic ejr, input logic rir,
                     input logic nir, input logic rov, input logic [7:0] rof, input logic ros,
                     input logic ejv, input logic [7:0] ejf, input logic err);
    vecs.push_back('{r, rf, rv, nf, nv, ror, ejr, rir, nir, rov, rof, ros, ejv, ejf, err});
  endtask

  function automatic logic [7:0] rand_nonhead();
    logic [7:0] b;
    do b = 8'($urandom); while (b[7:2] == HT);
    return b;
  endfunction

  function automatic logic [7:0] rand_body();
    logic [7:0] b;
    do b = 8'($urandom); while (b == 8'hFF);
    return b;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [7:0] ring_s[$];
    logic [7:0] ni_s[$];
    int ridx, nidx, m_r, nloads, tail;
    logic hs_r, hs_n, ni_open, drop, done;
    logic m_ro_v, m_ro_s, m_ej_v, exp_err, ld_ro, ld_ej, ld_s;
    logic [7:0] m_ro_f, m_ej_f, ld_f, ld_ejf;

    //   rst rf   rv nf   nv ror ejr | rir nir rov rof  ros ejv ejf  err
    // Local ejection of BE 55 FF.
    add(1, 8'h00, 0, 8'h00, 0, 1, 1,  1, 1, 0, 8'h00, 0, 0, 8'h00, 0);
    add(0, 8'hBE, 1, 8'h00, 0, 1, 1,  1, 1, 0, 8'h00, 0, 0, 8'h00, 0);
    add(0, 8'h55, 1, 8'h00, 0, 1, 1,  1, 1, 0, 8'h00, 0, 1, 8'hBE, 0);
    add(0, 8'hFF, 1, 8'h00, 0, 1, 1,  1, 1, 0, 8'h00, 0, 1, 8'h55, 0);
    add(0, 8'h00, 0, 8'h00, 0, 1, 1,  1, 1, 0, 8'h00, 0, 1, 8'hFF, 0);
    add(0, 8'h00, 0, 8'h00, 0, 1, 1,  1, 1, 0, 8'h00, 0, 0, 8'hFF, 0);
    // Forward BD 11 FF to the ring.
    add(0, 8'hBD, 1, 8'h00, 0, 1, 1,  1, 1, 0, 8'h00, 0, 0, 8'hFF, 0);
    add(0, 8'h11, 1, 8'h00, 0, 1, 1,  1, 0, 1, 8'hBD, 0, 0, 8'hFF, 0);
    add(0, 8'hFF, 1, 8'h00, 0, 1, 1,  1, 0, 1, 8'h11, 0, 0, 8'hFF, 0);
    add(0, 8'h00, 0, 8'h00, 0, 1, 1,  1, 1, 1, 8'hFF, 0, 0, 8'hFF, 0);
    add(0, 8'h00, 0, 8'h00, 0, 1, 1,  1, 1, 0, 8'hFF, 0, 0, 8'hFF, 0);
    // Tie with rr=0: ring wins, NI follows.
    add(0, 8'hBD, 1, 8'hBC, 1, 1, 1,  1, 0, 0, 8'hFF, 0, 0, 8'hFF, 0);
    add(0, 8'h22, 1, 8'hBC, 1, 1, 1,  1, 0, 1, 8'hBD, 0, 0, 8'hFF, 0);
    add(0, 8'hFF, 1, 8'hBC, 1, 1, 1,  1, 0, 1, 8'h22, 0, 0, 8'hFF, 0);
    add(0, 8'h00, 0, 8'hBC, 1, 1, 1,  1, 1, 1, 8'hFF, 0, 0, 8'hFF, 0);
    add(0, 8'h00, 0, 8'h33, 1, 1, 1,  1, 1, 1, 8'hBC, 1, 0, 8'hFF, 0);
    add(0, 8'h00, 0, 8'hFF, 1, 1, 1,  1, 1, 1, 8'h33, 1, 0, 8'hFF, 0);
    add(0, 8'h00, 0, 8'h00, 0, 1, 1,  1, 1, 1, 8'hFF, 1, 0, 8'hFF, 0);
    // Repeated tie: NI wins this time.
    add(0, 8'hBD, 1, 8'hBC, 1, 1, 1,  0, 1, 0, 8'hFF, 1, 0, 8'hFF, 0);
    add(0, 8'hBD, 1, 8'hFF, 1, 1, 1,  0, 1, 1, 8'hBC, 1, 0, 8'hFF, 0);
    add(0, 8'hBD, 1, 8'h00, 0, 1, 1,  1, 1, 1, 8'hFF, 1, 0, 8'hFF, 0);
    add(0, 8'hFF, 1, 8'h00, 0, 1, 1,  1, 0, 1, 8'hBD, 0, 0, 8'hFF, 0);
    add(0, 8'h00, 0, 8'h00, 0, 1, 1,  1, 1, 1, 8'hFF, 0, 0, 8'hFF, 0);
    add(0, 8'h00, 0, 8'h00, 0, 1, 1,  1, 1, 0, 8'hFF, 0, 0, 8'hFF, 0);
    // Downstream stall for five cycles mid-packet.
    add(0, 8'hBD, 1, 8'h00, 0, 1, 1,  1, 1, 0, 8'hFF, 0, 0, 8'hFF, 0);
    for (int k = 0; k < 5; k++)
      add(0, 8'h44, 1, 8'h00, 0, 0, 1,  0, 0, 1, 8'hBD, 0, 0, 8'hFF, 0);
    add(0, 8'h44, 1, 8'h00, 0, 1, 1,  1, 0, 1, 8'hBD, 0, 0, 8'hFF, 0);
    add(0, 8'h55, 1, 8'h00, 0, 1, 1,  1, 0, 1, 8'h44, 0, 0, 8'hFF, 0);
    add(0, 8'hFF, 1, 8'h00, 0, 1, 1,  1, 0, 1, 8'h55, 0, 0, 8'hFF, 0);
    add(0, 8'h00, 0, 8'h00, 0, 1, 1,  1, 1, 1, 8'hFF, 0, 0, 8'hFF, 0);
    add(0, 8'h00, 0, 8'h00, 0, 1, 1,  1, 1, 0, 8'hFF, 0, 0, 8'hFF, 0);
    // Stray non-head flits: ring alone, then both inputs together.
    add(0, 8'h42, 1, 8'h00, 0, 1, 1,  1, 1, 0, 8'hFF, 0, 0, 8'hFF, 0);
    add(0, 8'h00, 0, 8'h00, 0, 1, 1,  1, 1, 0, 8'hFF, 0, 0, 8'hFF, 1);
    add(0, 8'h00, 0, 8'h00, 0, 1, 1,  1, 1, 0, 8'hFF, 0, 0, 8'hFF, 0);
    add(0, 8'h42, 1, 8'h43, 1, 1, 1,  1, 1, 0, 8'hFF, 0, 0, 8'hFF, 0);
    add(0, 8'h00, 0, 8'h00, 0, 1, 1,  1, 1, 0, 8'hFF, 0, 0, 8'hFF, 1);
    add(0, 8'h00, 0, 8'h00, 0, 1, 1,  1, 1, 0, 8'hFF, 0, 0, 8'hFF, 0);
    // Concurrent eject and inject, reset mid-packet, then a fresh packet.
    add(0, 8'hBE, 1, 8'hBD, 1, 1, 1,  1, 1, 0, 8'hFF, 0, 0, 8'hFF, 0);
    add(0, 8'h61, 1, 8'h62, 1, 1, 1,  1, 1, 1, 8'hBD, 1, 1, 8'hBE, 0);
    add(1, 8'h63, 1, 8'h64, 1, 1, 1,  1, 1, 1, 8'h62, 1, 1, 8'h61, 0);
    add(0, 8'h00, 0, 8'h00, 0, 1, 1,  1, 1, 0, 8'h00, 0, 0, 8'h00, 0);
    add(0, 8'hBE, 1, 8'h00, 0, 1, 1,  1, 1, 0, 8'h00, 0, 0, 8'h00, 0);
    add(0, 8'hFF, 1, 8'h00, 0, 1, 1,  1, 1, 0, 8'h00, 0, 1, 8'hBE, 0);
    add(0, 8'h00, 0, 8'h00, 0, 1, 1,  1, 1, 0, 8'h00, 0, 1, 8'hFF, 0);
    add(0, 8'h00, 0, 8'h00, 0, 1, 1,  1, 1, 0, 8'h00, 0, 0, 8'hFF, 0);

    current_node   = NODE;
    rst            = 1'b1;
    ring_in_flit   = '0; ring_in_valid = 1'b0;
    ni_in_flit     = '0; ni_in_valid   = 1'b0;
    ring_out_ready = 1'b1; ej_ready    = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      v = vecs[i];
      @(posedge clk); #1;
      rst = v.rst;
      ring_in_flit = v.rf; ring_in_valid = v.rv;
      ni_in_flit = v.nf;   ni_in_valid = v.nv;
      ring_out_ready = v.ror; ej_ready = v.ejr;
      @(negedge clk);
      chk1($sformatf("row%0d ring_in_ready", i), ring_in_ready, v.rir);
      chk1($sformatf("row%0d ni_in_ready", i), ni_in_ready, v.nir);
      chk1($sformatf("row%0d ring_out_valid", i), ring_out_valid, v.rov);
      chk8($sformatf("row%0d ring_out_flit", i), ring_out_flit, v.rof);
      chk1($sformatf("row%0d ring_out_src", i), ring_out_src, v.ros);
      chk1($sformatf("row%0d ej_valid", i), ej_valid, v.ejv);
      chk8($sformatf("row%0d ej_flit", i), ej_flit, v.ejf);
      chk1($sformatf("row%0d err_drop", i), err_drop, v.err);
    end

    // Random packet streams, with occasional stray non-head flits between packets.
    for (int p = 0; p < 60; p++) begin
      if ($urandom_range(0, 4) == 0) ring_s.push_back(rand_nonhead());
      ring_s.push_back({HT, 2'($urandom_range(0, 3))});
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) ring_s.push_back(rand_body());
      ring_s.push_back(8'hFF);
      if ($urandom_range(0, 4) == 0) ni_s.push_back(rand_nonhead());
      ni_s.push_back({HT, 2'($urandom_range(0, 3))});
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) ni_s.push_back(rand_body());
      ni_s.push_back(8'hFF);
    end

    ridx = 0; nidx = 0; m_r = 0; ni_open = 1'b0; tail = 0; done = 1'b0;
    hs_r = 1'b0; hs_n = 1'b0; exp_err = 1'b0;
    m_ro_v = 1'b0; m_ro_s = 1'b0; m_ro_f = '0; m_ej_v = 1'b0; m_ej_f = '0;

    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(posedge clk); #1;
      if (hs_r) ridx++;
      if (hs_n) nidx++;
      if (ridx < ring_s.size()) begin
        if (!(ring_in_valid && !hs_r)) ring_in_valid = ($urandom_range(0, 3) != 0);
        ring_in_flit = ring_s[ridx];
      end else begin
        ring_in_valid = 1'b0; ring_in_flit = '0;
      end
      if (nidx < ni_s.size()) begin
        if (!(ni_in_valid && !hs_n)) ni_in_valid = ($urandom_range(0, 3) != 0);
        ni_in_flit = ni_s[nidx];
      end else begin
        ni_in_valid = 1'b0; ni_in_flit = '0;
      end
      if (ridx >= ring_s.size() && nidx >= ni_s.size()) begin
        ring_out_ready = 1'b1; ej_ready = 1'b1;
      end else begin
        ring_out_ready = ($urandom_range(0, 3) != 0);
        ej_ready       = ($urandom_range(0, 3) != 0);
      end

      @(negedge clk);
      chk1("rnd ring_out_valid", ring_out_valid, m_ro_v);
      if (m_ro_v) begin
        chk8("rnd ring_out_flit", ring_out_flit, m_ro_f);
        chk1("rnd ring_out_src", ring_out_src, m_ro_s);
      end
      chk1("rnd ej_valid", ej_valid, m_ej_v);
      if (m_ej_v) chk8("rnd ej_flit", ej_flit, m_ej_f);
      chk1("rnd err_drop", err_drop, exp_err);
      if (m_r == 2) chk1("rnd ni_locked_out", ni_in_ready, 1'b0);
      if (ni_open && m_r == 0 && ring_in_valid && ring_in_flit[7:2] == HT && ring_in_flit[1:0] != NODE)
        chk1("rnd ring_fwd_stalled", ring_in_ready, 1'b0);
      if (m_r == 0 && ring_in_valid && ring_in_flit[7:2] != HT)
        chk1("rnd ring_stray_ready", ring_in_ready, 1'b1);

      hs_r = ring_in_valid && ring_in_ready;
      hs_n = ni_in_valid && ni_in_ready;
      nloads = 0; ld_ro = 1'b0; ld_ej = 1'b0; drop = 1'b0;
      ld_f = '0; ld_s = 1'b0; ld_ejf = '0;
      if (hs_r) begin
        if (m_r == 0) begin
          if (ring_in_flit[7:2] != HT) drop = 1'b1;
          else if (ring_in_flit[1:0] == NODE) begin ld_ej = 1'b1; ld_ejf = ring_in_flit; m_r = 1; end
          else begin ld_ro = 1'b1; nloads++; ld_f = ring_in_flit; ld_s = 1'b0; m_r = 2; end
        end else if (m_r == 1) begin
          ld_ej = 1'b1; ld_ejf = ring_in_flit;
          if (ring_in_flit == 8'hFF) m_r = 0;
        end else begin
          ld_ro = 1'b1; nloads++; ld_f = ring_in_flit; ld_s = 1'b0;
          if (ring_in_flit == 8'hFF) m_r = 0;
        end
      end
      if (hs_n) begin
        if (ni_open || ni_in_flit[7:2] == HT) begin
          ld_ro = 1'b1; nloads++; ld_f = ni_in_flit; ld_s = 1'b1;
          ni_open = (ni_in_flit != 8'hFF);
        end else begin
          drop = 1'b1;
        end
      end
      chk1("rnd single_ro_load", nloads <= 1, 1'b1);
      if (ld_ro) chk1("rnd ro_no_overwrite", !m_ro_v || ring_out_ready, 1'b1);
      if (ld_ej) chk1("rnd ej_no_overwrite", !m_ej_v || ej_ready, 1'b1);
      if (m_ro_v && ring_out_ready) m_ro_v = 1'b0;
      if (ld_ro) begin m_ro_v = 1'b1; m_ro_f = ld_f; m_ro_s = ld_s; end
      if (m_ej_v && ej_ready) m_ej_v = 1'b0;
      if (ld_ej) begin m_ej_v = 1'b1; m_ej_f = ld_ejf; end
      exp_err = drop;

      if (ridx + int'(hs_r) >= ring_s.size() && nidx + int'(hs_n) >= ni_s.size() && !m_ro_v && !m_ej_v) begin
        tail++;
        if (tail > 3) done = 1'b1;
      end
    end
    chk1("rnd streams_complete", done, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
